uart_frame_parser: RTL and testbench

- Sits directly downstream of the 8N1 UART receiver and consumes its one-cycle byte strobe and data byte.
- Hunts for a sync byte, then collects a length-prefixed payload into an internal buffer and checks an 8-bit additive checksum.
- Releases only checksum-good frames to the command logic over a valid/ready byte stream, with an end-of-frame marker.
- Bad or truncated frames are discarded and flagged.

---
 rtl/uart_frame_parser.sv | 198 +++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Sync/length/checksum framer behind the UART receiver; releases good payloads on a valid/ready stream.
// Optional inter-byte timeout enabled with `define UART_PARSER_TIMEOUT_EN.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       drop_pulse
);

  localparam int unsigned PW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] len_q, len_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_next;
  logic [7:0]    acc_q, acc_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          drop_q, drop_d;
  logic          buf_we;
  logic [7:0]    buf_q [MAX_LEN];

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYC;
`endif

  assign rd_next = rd_ptr_q + PW'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frame_err_d = 1'b0;
    err_code_d  = 2'b00;
    drop_d      = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_data == 8'd0 || rx_data > 8'(MAX_LEN)) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = S_IDLE;
          end else begin
            len_d    = PW'(rx_data);
            acc_d    = rx_data;
            wr_ptr_d = '0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          buf_we   = 1'b1;
          acc_d    = acc_q + rx_data;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (wr_ptr_q + PW'(1) == len_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data == acc_q) begin
            rd_ptr_d    = '0;
            out_valid_d = 1'b1;
            out_data_d  = buf_q[AW'(0)];
            out_last_d  = (len_q == PW'(1));
            state_d     = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (rx_valid) drop_d = 1'b1;
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = 8'd0;
            state_d     = S_IDLE;
          end else begin
            rd_ptr_d   = rd_next;
            out_data_d = buf_q[AW'(rd_next)];
            out_last_d = (rd_next == len_q - PW'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef UART_PARSER_TIMEOUT_EN
    // Counter runs only while a frame is being collected; a coincident byte beats expiry
    tmo_d = '0;
    if (state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHK) begin
      if (rx_valid) begin
        tmo_d = TW'(TIMEOUT_CYC);
      end else if (tmo_q <= TW'(1)) begin
        frame_err_d = 1'b1;
        err_code_d  = 2'b11;
        state_d     = S_IDLE;
      end else begin
        tmo_d = tmo_q - TW'(1);
      end
    end else if (state_q == S_IDLE && rx_valid && rx_data == SYNC_BYTE) begin
      tmo_d = TW'(TIMEOUT_CYC);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      acc_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      drop_q      <= drop_d;
    end
  end

`ifdef UART_PARSER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  // Payload storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[AW'(wr_ptr_q)] <= rx_data;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign drop_pulse = drop_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames plus randomized frames against a byte-list model.
module tb_uart_frame_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam int unsigned TMO     = 50;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       out_ready = 1'b0;
  logic       out_valid, out_last, frame_err, drop_pulse;
  logic [7:0] out_data;
  logic [1:0] err_code;

  int vectors = 0;
  int miscompares = 0;
  int drop_cnt = 0;
  bit rnd_ready = 1'b0;

  logic [8:0] got_q[$];
  logic [1:0] err_q[$];
  logic [8:0] exp_out_q[$];
  logic [1:0] exp_err_q[$];

  always #5 clk = ~clk;

  uart_frame_parser #(
    .MAX_LEN(MAX_LEN),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .frame_err(frame_err),
    .err_code(err_code),
    .drop_pulse(drop_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: collects transfers/errors and checks hold, exclusivity and idle err_code
  logic       stall_q = 1'b0;
  logic [8:0] held_q  = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'({out_last, out_data}), 32'(held_q));
      end
      if (!frame_err) check("err_code_quiet", 32'(err_code), 0);
      check("err_drop_excl", 32'(frame_err & drop_pulse), 0);
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (frame_err) err_q.push_back(err_code);
      if (drop_pulse) drop_cnt++;
      stall_q = out_valid & ~out_ready;
      held_q  = {out_last, out_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic send_bytes(input bq_t q, input int max_gap);
    foreach (q[i]) begin
      if (i != 0) repeat ($urandom_range(0, max_gap)) tick();
      send_byte(q[i]);
    end
  endtask

  task automatic wait_out(input int n);
    for (int c = 0; c < 600 && got_q.size() < n; c++) tick();
    check("wait_out_count", 32'(got_q.size()), 32'(n));
  endtask

  task automatic clear_q();
    got_q.delete();
    err_q.delete();
    exp_out_q.delete();
    exp_err_q.delete();
  endtask

  // Reference: scan a byte list for SYNC, LEN, payload, CHK and derive outputs/discards
  function automatic void model(input bq_t q);
    int i;
    int len;
    logic [7:0] sum;
    i = 0;
    while (i < q.size()) begin
      if (q[i] != SYNC) begin
        i++;
      end else if (i + 1 >= q.size()) begin
        i = q.size();
      end else begin
        len = int'(q[i+1]);
        if (len == 0 || len > int'(MAX_LEN)) begin
          exp_err_q.push_back(2'b01);
          i += 2;
        end else if (i + 2 + len >= q.size()) begin
          i = q.size();
        end else begin
          sum = q[i+1];
          for (int k = 0; k < len; k++) sum = sum + q[i+2+k];
          if (q[i+2+len] == sum) begin
            for (int k = 0; k < len; k++) exp_out_q.push_back({(k == len - 1), q[i+2+k]});
          end else begin
            exp_err_q.push_back(2'b10);
          end
          i += len + 3;
        end
      end
    end
  endfunction

  task automatic compare_queues(input string tag);
    check({tag, "_out_count"}, 32'(got_q.size()), 32'(exp_out_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_out_q.size(); i++)
      check({tag, "_out_byte"}, 32'(got_q[i]), 32'(exp_out_q[i]));
    check({tag, "_err_count"}, 32'(err_q.size()), 32'(exp_err_q.size()));
    for (int i = 0; i < err_q.size() && i < exp_err_q.size(); i++)
      check({tag, "_err_code"}, 32'(err_q[i]), 32'(exp_err_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t fr;
    int kind;
    int len;
    logic [7:0] chk;
    logic [7:0] b;

    // Reset state
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_err", 32'({frame_err, err_code}), 0);
    check("rst_drop", 32'(drop_pulse), 0);
    rst = 1'b0;
    tick();

    // Good frame, exact timing
    out_ready = 1'b1;
    clear_q();
    send_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 0);
    check("good_v0", 32'(out_valid), 1);
    check("good_d0", 32'({out_last, out_data}), 32'h011);
    tick();
    check("good_d1", 32'({out_valid, out_last, out_data}), 32'h222);
    tick();
    check("good_d2", 32'({out_valid, out_last, out_data}), 32'h333);
    tick();
    check("good_end", 32'(out_valid), 0);
    check("good_errs", 32'(err_q.size()), 0);

    // Backpressure
    clear_q();
    out_ready = 1'b0;
    send_bytes('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 0);
    for (int c = 0; c < 5; c++) begin
      check("bp_stall", 32'({out_valid, out_last, out_data}), 32'h211);
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got_q.size() < 3; c++) begin
      tick();
      out_ready = ~out_ready;
    end
    tick();
    check("bp_end", 32'(out_valid), 0);
    out_ready = 1'b1;
    exp_out_q = '{9'h011, 9'h022, 9'h133};
    compare_queues("bp");

    // Bad checksum, then a single-byte frame
    clear_q();
    send_bytes('{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00}, 0);
    check("chk_err", 32'({frame_err, err_code}), 32'h6);
    check("chk_noout", 32'(out_valid), 0);
    tick();
    check("chk_pulse1", 32'(frame_err), 0);
    send_bytes('{8'hA5, 8'h01, 8'h7E, 8'h7F}, 0);
    check("one_byte", 32'({out_valid, out_last, out_data}), 32'h37E);
    tick();
    check("one_end", 32'(out_valid), 0);

    // Bad lengths and noise
    clear_q();
    send_bytes('{8'hA5, 8'h00}, 0);
    check("len0_err", 32'({frame_err, err_code}), 32'h5);
    send_byte(8'h3C);
    check("noise_quiet", 32'(frame_err), 0);
    send_bytes('{8'hA5, 8'(MAX_LEN + 1)}, 0);
    check("lenmax_err", 32'({frame_err, err_code}), 32'h5);
    repeat (2) tick();
    check("len_errs", 32'(err_q.size()), 2);
    check("len_noout", 32'(got_q.size()), 0);

    // Drain collision
    clear_q();
    drop_cnt  = 0;
    out_ready = 1'b0;
    send_bytes('{8'hA5, 8'h02, 8'hC1, 8'hC2, 8'h85}, 0);
    send_byte(SYNC);
    check("drop_pulse", 32'(drop_pulse), 1);
    check("drop_hold", 32'({out_valid, out_data}), 32'h1C1);
    tick();
    check("drop_once", 32'(drop_pulse), 0);
    out_ready = 1'b1;
    wait_out(2);
    tick();
    check("drop_end", 32'(out_valid), 0);
    send_bytes('{8'hA5, 8'h01, 8'h55, 8'h56}, 0);
    check("drop_next", 32'({out_valid, out_last, out_data}), 32'h355);
    tick();
    exp_out_q = '{9'h0C1, 9'h1C2, 9'h155};
    compare_queues("drain");
    check("drop_cnt", 32'(drop_cnt), 1);

    // Truncated frame
    clear_q();
    send_bytes('{8'hA5, 8'h04, 8'h01}, 0);
`ifdef UART_PARSER_TIMEOUT_EN
    for (int c = 1; c < int'(TMO); c++) begin
      tick();
      check("tmo_early", 32'(frame_err), 0);
    end
    tick();
    check("tmo_err", 32'({frame_err, err_code}), 32'h7);
`else
    repeat (100) tick();
    check("tmo_none", 32'(err_q.size()), 0);
    send_bytes('{8'h02, 8'h03, 8'h04, 8'h0E}, 0);
    wait_out(4);
    tick();
    exp_out_q = '{9'h001, 9'h002, 9'h003, 9'h104};
    compare_queues("slow");
`endif

    // Reset mid-payload
    clear_q();
    send_bytes('{8'hA5, 8'h05, 8'h10, 8'h20}, 0);
    rst = 1'b1;
    tick();
    check("mid_rst_outs", 32'({out_valid, out_last, out_data, frame_err, err_code, drop_pulse}), 0);
    rst = 1'b0;
    send_bytes('{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05}, 0);
    wait_out(2);
    tick();
    exp_out_q = '{9'h001, 9'h102};
    compare_queues("post_rst");

    // Randomized frames against the reference
    drop_cnt  = 0;
    rnd_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      clear_q();
      fr.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        fr.push_back(b);
      end
      fr.push_back(SYNC);
      kind = $urandom_range(0, 3);
      if (kind == 2) begin
        fr.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        len = (kind == 3) ? int'(MAX_LEN) : $urandom_range(1, MAX_LEN);
        fr.push_back(8'(len));
        chk = 8'(len);
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom);
          fr.push_back(b);
          chk = chk + b;
        end
        if (kind == 1) chk = chk ^ 8'($urandom_range(1, 255));
        fr.push_back(chk);
      end
      model(fr);
      send_bytes(fr, 3);
      for (int c = 0; c < 600 && got_q.size() < exp_out_q.size(); c++) tick();
      repeat (2) tick();
      compare_queues("rnd");
    end
    check("rnd_drops", 32'(drop_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
